// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared types and constants for the two-master MMIO arbiter
package mmio_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int M0 = 0;
    localparam int M1 = 1;
    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 6;
    localparam logic [1:0] GNT_NONE = 2'b00;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way winner select, one-hot grant
//   req  : request levels, bit 0 = M0, bit 1 = M1
//   last : master granted most recently (0 = M0, 1 = M1)
//   gnt  : one-hot winner, 00 when nobody requests
// Build option MMIO_ARB_FIXED_PRIO_EN: M0 always wins contention, last ignored.
module rr_pick2
    import mmio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
`ifdef MMIO_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign gnt = req[M0] ? 2'b01 : req;
`else
    // Under contention the master that did not win last time goes next.
    assign gnt = (&req) ? ((last == 1'(M1)) ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: serialises two masters onto one MMIO device port
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   M0_*/M1_*           : per-master Req level, word Add, Write, WData; Ack pulse out
//   RData               : read data of the last completed access, valid with Ack
//   Gnt                 : one-hot owner of the device port, 00 = idle
//   Dev_Add/Write/WData : registered device port; Dev_RData returns combinationally
// Build option MMIO_ARB_FIXED_PRIO_EN (inside rr_pick2): fixed M0 priority.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          M0_Req,
    input  logic [AW-1:0] M0_Add,
    input  logic          M0_Write,
    input  logic [DW-1:0] M0_WData,
    output logic          M0_Ack,
    input  logic          M1_Req,
    input  logic [AW-1:0] M1_Add,
    input  logic          M1_Write,
    input  logic [DW-1:0] M1_WData,
    output logic          M1_Ack,
    output logic [DW-1:0] RData,
    output logic [1:0]    Gnt,
    output logic [AW-1:0] Dev_Add,
    output logic          Dev_Write,
    output logic [DW-1:0] Dev_WData,
    input  logic [DW-1:0] Dev_RData
);
    state_t        state, state_n;
    logic [1:0]    ack, ack_n, gnt_n, pick;
    logic          last, last_n, write_n;
    logic [AW-1:0] add_n;
    logic [DW-1:0] wdata_n, rdata_n;

    assign M0_Ack = ack[M0];
    assign M1_Ack = ack[M1];

    rr_pick2 u_pick (
        .req  ({M1_Req, M0_Req}),
        .last (last),
        .gnt  (pick)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            Gnt       <= GNT_NONE;
            ack       <= 2'b00;
            Dev_Write <= 1'b0;
            Dev_Add   <= '0;
            Dev_WData <= '0;
            RData     <= '0;
            last      <= 1'(M1);
        end else begin
            state     <= state_n;
            Gnt       <= gnt_n;
            ack       <= ack_n;
            Dev_Write <= write_n;
            Dev_Add   <= add_n;
            Dev_WData <= wdata_n;
            RData     <= rdata_n;
            last      <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = Gnt;
        ack_n   = ack;
        write_n = Dev_Write;
        add_n   = Dev_Add;
        wdata_n = Dev_WData;
        rdata_n = RData;
        last_n  = last;
        case (state)
            IDLE: begin
                if (|pick) begin
                    gnt_n   = pick;
                    add_n   = pick[M1] ? M1_Add : M0_Add;
                    wdata_n = pick[M1] ? M1_WData : M0_WData;
                    write_n = pick[M1] ? M1_Write : M0_Write;
                    last_n  = pick[M1];
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                // Writes capture Dev_RData too; RData simply tracks the last access.
                rdata_n = Dev_RData;
                write_n = 1'b0;
                ack_n   = Gnt;
                state_n = RESP;
            end
            RESP: begin
                ack_n   = 2'b00;
                gnt_n   = GNT_NONE;
                state_n = IDLE;
            end
            default: begin
                ack_n   = 2'b00;
                gnt_n   = GNT_NONE;
                write_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end
endmodule
